instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the instruction decoder: takes a symbolic RV32I instruction (mnemonic code, register indices, immediate) over a valid/ready handshake.
- Produces the 32-bit machine word and writes it to instruction memory at sequential word addresses.
- Serves as the didactic platform's program loader between the host/UART front-end and instruction memory.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first written word (must be 4-aligned).
- DEPTH, 256, maximum number of words written before the block reports full.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset; asynchronous, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  block can accept a request.
- op_i  in  6  mnemonic code (see Behaviour).
- rd_i  in  5  destination register.
- rs1_i  in  5  source register 1.
- rs2_i  in  5  source register 2.
- imm_i  in  32  immediate. Signed byte offset for I/S/B/J types; shamt in [4:0]; U-type upper 20 bits in [19:0].
- clear_i  in  1  synchronous restart of the write address.
- mem_wr_o  out  1  one-cycle write strobe.
- mem_addr_o  out  32  write byte address.
- mem_wr_data_o  out  32  encoded instruction.
- err_o  out  1  one-cycle error pulse.
- err_code_o  out  2  00 none, 01 invalid op, 10 immediate out of range; held until next accept.
- full_o  out  1  DEPTH words written.
- count_o  out  16  words written since reset/clear.

Behaviour:
- op_i codes:
  - 0 LUI, 1 AUIPC, 2 JAL, 3 JALR.
  - 4-9: BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - 10-14: LB, LH, LW, LBU, LHU.
  - 15-17: SB, SH, SW.
  - 18-26: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - 27-36: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - 37-63 are invalid.
- Opcode, funct3 and funct7 values follow the RV32I base ISA. SUB/SRA/SRAI use funct7 0100000.
- Unused fields per format are ignored; for example rd_i for S/B and rs2_i for I.
- FSM states: IDLE, ENC, WR, FULL.
  - IDLE: req_ready_o=1 iff clear_i=0. Handshake when req_valid_i & req_ready_o. All inputs are registered, then go to ENC.
  - ENC: encoding and checks are computed combinationally from the registered fields and registered into mem_wr_data_o/err_code_o.
    - Error: err_o=1 for one cycle, no write, address unchanged, back to IDLE.
    - Otherwise go to WR.
  - WR: mem_wr_o=1 for exactly one cycle with mem_addr_o = current address.
    - After the write: address += 4, count_o += 1.
    - Next state is FULL if count_o reaches DEPTH, else IDLE.
  - FULL: full_o=1, req_ready_o=0. Only clear_i or reset leaves this state.
- Latency: a request accepted at cycle N gives mem_wr_o (or err_o) at cycle N+2. Throughput is 1 instruction per 3 cycles.
- Range checks (when enabled):
  - I/load/JALR/S: imm in [-2048, 2047].
  - Shifts: imm_i[31:5]==0.
  - B: imm in [-4096, 4094] and imm[0]==0.
  - JAL: imm in [-1048576, 1048574] and imm[0]==0.
  - U: imm_i[31:20]==0.
- clear_i: in IDLE or FULL, the next cycle sets address=BASE_ADDR, count_o=0, full_o=0, state=IDLE.
  - In ENC/WR, clear_i takes effect after the current write/error completes.
  - clear_i forces req_ready_o=0, so a simultaneous request is not accepted.
- Reset (any time, including mid-operation) asynchronously sets:
  - state=IDLE, mem_wr_o=0, err_o=0, err_code_o=00, full_o=0, count_o=0.
  - mem_addr_o=BASE_ADDR, mem_wr_data_o=0, req_ready_o=1 after release.
- Any in-flight request is dropped by reset.

Optional Feature:
- Macro: ENC_RANGE_CHECK_EN.
- When defined: the immediate range and alignment checks above apply and raise err_code 10.
- When undefined: immediates are silently truncated to field width (B/J bit 0 dropped) and only invalid op raises an error.

Test Plan:
- Reset, then ADDI op=18 rd=1 rs1=0 imm=5 -> mem_wr_o at N+2, addr 0x0, data 0x00500093.
- ADD rd=3 rs1=1 rs2=2, then SUB with the same fields -> 0x002081B3 at 0x0, 0x402081B3 at 0x4, count_o=2.
- SW rs1=1 rs2=2 imm=8; BEQ rs1=1 rs2=2 imm=-4; LUI rd=5 imm=0x12345 -> 0x0020A423, 0xFE208EE3, 0x123452B7.
- With ENC_RANGE_CHECK_EN: ADDI imm=2048 -> err_o pulse, err_code_o=10, no mem_wr_o, next write still at the same address. op=40 -> err_code_o=01.
- DEPTH=2: three valid requests -> two writes, full_o=1, req_ready_o=0, third held. Assert clear_i -> third written at BASE_ADDR, count_o=1.
- Assert rst_n_i low during WR of an instruction -> outputs at reset values immediately, no mem_wr_o pulse after release.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: converts a symbolic RV32I instruction into its 32-bit machine
// word and writes it to instruction memory at sequential word addresses.
// Optional feature macro: ENC_RANGE_CHECK_EN (immediate range/alignment checks).
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 256
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [5:0]  op_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  input  logic        clear_i,
  output logic        mem_wr_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wr_data_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  output logic        full_o,
  output logic [15:0] count_o
);

  localparam logic [6:0]  OPC_LUI   = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC = 7'b0010111;
  localparam logic [6:0]  OPC_JAL   = 7'b1101111;
  localparam logic [6:0]  OPC_JALR  = 7'b1100111;
  localparam logic [6:0]  OPC_BR    = 7'b1100011;
  localparam logic [6:0]  OPC_LD    = 7'b0000011;
  localparam logic [6:0]  OPC_ST    = 7'b0100011;
  localparam logic [6:0]  OPC_IMM   = 7'b0010011;
  localparam logic [6:0]  OPC_OP    = 7'b0110011;
  localparam logic [15:0] DEPTH_W   = 16'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ENC, S_WR, S_FULL} state_t;

  state_t      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [31:0] imm_q, imm_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [15:0] count_q, count_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        err_q, err_d;
  logic        clr_pend_q, clr_pend_d;

  logic [31:0] enc_word;
  logic [1:0]  enc_err;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        rng_err;
  logic        fit_i, fit_b, fit_j, fit_sh, fit_u;
  logic        handshake, clear_eff;
  logic        unused_imm_hi;

  assign unused_imm_hi = ^imm_q[31:21];

`ifdef ENC_RANGE_CHECK_EN
  logic signed [31:0] imm_s;
  assign imm_s  = imm_q;
  assign fit_i  = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
  assign fit_b  = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !imm_q[0];
  assign fit_j  = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !imm_q[0];
  assign fit_sh = (imm_q[31:5] == '0);
  assign fit_u  = (imm_q[31:20] == '0);
`else
  assign fit_i  = 1'b1;
  assign fit_b  = 1'b1;
  assign fit_j  = 1'b1;
  assign fit_sh = 1'b1;
  assign fit_u  = 1'b1;
`endif

  assign handshake   = (state_q == S_IDLE) && req_valid_i && !clear_i;
  assign clear_eff   = clear_i || clr_pend_q;
  assign req_ready_o = (state_q == S_IDLE) && !clear_i;
  assign mem_wr_o    = (state_q == S_WR);
  assign full_o      = (state_q == S_FULL);
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;
  assign mem_addr_o  = addr_q;
  assign mem_wr_data_o = data_q;
  assign count_o     = count_q;

  // Instruction word assembly and validity checks from the registered fields
  always_comb begin
    enc_word = '0;
    enc_err  = 2'b00;
    rng_err  = 1'b0;
    case (op_q)
      6'd5, 6'd11, 6'd16, 6'd24, 6'd29:        f3 = 3'd1;
      6'd12, 6'd17, 6'd19, 6'd30:              f3 = 3'd2;
      6'd20, 6'd31:                            f3 = 3'd3;
      6'd6, 6'd13, 6'd21, 6'd32:               f3 = 3'd4;
      6'd7, 6'd14, 6'd25, 6'd26, 6'd33, 6'd34: f3 = 3'd5;
      6'd8, 6'd22, 6'd35:                      f3 = 3'd6;
      6'd9, 6'd23, 6'd36:                      f3 = 3'd7;
      default:                                 f3 = 3'd0;
    endcase
    f7 = (op_q == 6'd26 || op_q == 6'd28 || op_q == 6'd34) ? 7'b0100000 : 7'b0000000;
    case (op_q) inside
      6'd0: begin
        enc_word = {imm_q[19:0], rd_q, OPC_LUI};
        rng_err  = !fit_u;
      end
      6'd1: begin
        enc_word = {imm_q[19:0], rd_q, OPC_AUIPC};
        rng_err  = !fit_u;
      end
      6'd2: begin
        enc_word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, OPC_JAL};
        rng_err  = !fit_j;
      end
      6'd3: begin
        enc_word = {imm_q[11:0], rs1_q, 3'b000, rd_q, OPC_JALR};
        rng_err  = !fit_i;
      end
      [6'd4:6'd9]: begin
        enc_word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3, imm_q[4:1], imm_q[11], OPC_BR};
        rng_err  = !fit_b;
      end
      [6'd10:6'd14]: begin
        enc_word = {imm_q[11:0], rs1_q, f3, rd_q, OPC_LD};
        rng_err  = !fit_i;
      end
      [6'd15:6'd17]: begin
        enc_word = {imm_q[11:5], rs2_q, rs1_q, f3, imm_q[4:0], OPC_ST};
        rng_err  = !fit_i;
      end
      [6'd18:6'd23]: begin
        enc_word = {imm_q[11:0], rs1_q, f3, rd_q, OPC_IMM};
        rng_err  = !fit_i;
      end
      [6'd24:6'd26]: begin
        enc_word = {f7, imm_q[4:0], rs1_q, f3, rd_q, OPC_IMM};
        rng_err  = !fit_sh;
      end
      [6'd27:6'd36]: begin
        enc_word = {f7, rs2_q, rs1_q, f3, rd_q, OPC_OP};
      end
      default: enc_err = 2'b01;
    endcase
    if (enc_err == 2'b00 && rng_err) enc_err = 2'b10;
  end

  // Next-state logic of the accept/encode/write sequence
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (handshake) state_d = S_ENC;
      S_ENC:  state_d = (enc_err != 2'b00) ? S_IDLE : S_WR;
      S_WR: begin
        if (clear_eff)                         state_d = S_IDLE;
        else if (count_q + 16'd1 == DEPTH_W)   state_d = S_FULL;
        else                                   state_d = S_IDLE;
      end
      S_FULL: if (clear_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates: field capture, result capture, address/count bookkeeping
  always_comb begin
    op_d       = op_q;
    rd_d       = rd_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    imm_d      = imm_q;
    addr_d     = addr_q;
    data_d     = data_q;
    count_d    = count_q;
    err_code_d = err_code_q;
    err_d      = 1'b0;
    clr_pend_d = clr_pend_q;
    case (state_q)
      S_IDLE: begin
        if (clear_i) begin
          addr_d  = BASE_ADDR;
          count_d = '0;
        end else if (handshake) begin
          op_d       = op_i;
          rd_d       = rd_i;
          rs1_d      = rs1_i;
          rs2_d      = rs2_i;
          imm_d      = imm_i;
          err_code_d = 2'b00;
          clr_pend_d = 1'b0;
        end
      end
      S_ENC: begin
        // A clear seen here is deferred until the write/error completes.
        clr_pend_d = clear_eff;
        err_code_d = enc_err;
        if (enc_err != 2'b00) begin
          err_d = 1'b1;
          if (clear_eff) begin
            addr_d     = BASE_ADDR;
            count_d    = '0;
            clr_pend_d = 1'b0;
          end
        end else begin
          data_d = enc_word;
        end
      end
      S_WR: begin
        if (clear_eff) begin
          addr_d     = BASE_ADDR;
          count_d    = '0;
          clr_pend_d = 1'b0;
        end else begin
          addr_d  = addr_q + 32'd4;
          count_d = count_q + 16'd1;
        end
      end
      S_FULL: begin
        if (clear_i) begin
          addr_d  = BASE_ADDR;
          count_d = '0;
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      imm_q      <= '0;
      addr_q     <= BASE_ADDR;
      data_q     <= '0;
      count_q    <= '0;
      err_code_q <= 2'b00;
      err_q      <= 1'b0;
      clr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      imm_q      <= imm_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      count_q    <= count_d;
      err_code_q <= err_code_d;
      err_q      <= err_d;
      clr_pend_q <= clr_pend_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: table vectors, randomized requests against a
// reference encoder, reset-during-write and a DEPTH=2 full/clear sequence.
module tb_instr_encoder;

  localparam logic [31:0] BASE_B = 32'h0000_1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, valid, clear, sel;
  logic [5:0]  op;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;

  logic        a_ready, a_wr, a_err, a_full;
  logic [31:0] a_addr, a_data;
  logic [1:0]  a_code;
  logic [15:0] a_cnt;
  logic        b_ready, b_wr, b_err, b_full;
  logic [31:0] b_addr, b_data;
  logic [1:0]  b_code;
  logic [15:0] b_cnt;

  logic        c_ready, c_wr, c_err, c_full;
  logic [31:0] c_addr, c_data;
  logic [1:0]  c_code;
  logic [15:0] c_cnt;

  assign c_ready = sel ? b_ready : a_ready;
  assign c_wr    = sel ? b_wr    : a_wr;
  assign c_err   = sel ? b_err   : a_err;
  assign c_full  = sel ? b_full  : a_full;
  assign c_addr  = sel ? b_addr  : a_addr;
  assign c_data  = sel ? b_data  : a_data;
  assign c_code  = sel ? b_code  : a_code;
  assign c_cnt   = sel ? b_cnt   : a_cnt;

  instr_encoder u_a (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(valid && !sel), .req_ready_o(a_ready),
    .op_i(op), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm), .clear_i(clear && !sel),
    .mem_wr_o(a_wr), .mem_addr_o(a_addr), .mem_wr_data_o(a_data), .err_o(a_err),
    .err_code_o(a_code), .full_o(a_full), .count_o(a_cnt)
  );

  instr_encoder #(.BASE_ADDR(BASE_B), .DEPTH(2)) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(valid && sel), .req_ready_o(b_ready),
    .op_i(op), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm), .clear_i(clear && sel),
    .mem_wr_o(b_wr), .mem_addr_o(b_addr), .mem_wr_data_o(b_data), .err_o(b_err),
    .err_code_o(b_code), .full_o(b_full), .count_o(b_cnt)
  );

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_addr [2];
  int unsigned exp_cnt [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference encoder: format/funct3 looked up by mnemonic index, fields
  // placed according to the RV32I instruction formats. Returns {err_code, word}.
  function automatic logic [33:0] model_enc(input logic [5:0] o, input logic [4:0] d,
                                             input logic [4:0] s1, input logic [4:0] s2,
                                             input logic [31:0] im);
    string       fmt_tab = "UUJIBBBBBBLLLLLSSSIIIIIIHHHRRRRRRRRRR";
    string       f3_tab  = "0000014567012450120234671550012345567";
    byte         fmt;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [6:0]  opc;
    logic [31:0] w;
    int          s;
    logic        bad;
    if (o > 6'd36) return {2'b01, 32'h0};
    fmt = fmt_tab[o];
    f3  = 3'(f3_tab[o] - 8'd48);
    f7  = (o == 26 || o == 28 || o == 34) ? 7'h20 : 7'h00;
    s   = im;
    bad = 1'b0;
    case (fmt)
      "U": begin
        opc = (o == 0) ? 7'h37 : 7'h17;
        w   = {im[19:0], d, opc};
        bad = (im[31:20] != 0);
      end
      "J": begin
        w   = {im[20], im[10:1], im[11], im[19:12], d, 7'h6F};
        bad = (s < -1048576) || (s > 1048574) || im[0];
      end
      "B": begin
        w   = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], 7'h63};
        bad = (s < -4096) || (s > 4094) || im[0];
      end
      "S": begin
        w   = {im[11:5], s2, s1, f3, im[4:0], 7'h23};
        bad = (s < -2048) || (s > 2047);
      end
      "H": begin
        w   = {f7, im[4:0], s1, f3, d, 7'h13};
        bad = (im[31:5] != 0);
      end
      "R": w = {f7, s2, s1, f3, d, 7'h33};
      default: begin
        opc = (fmt == "L") ? 7'h03 : ((o == 3) ? 7'h67 : 7'h13);
        w   = {im[11:0], s1, f3, d, opc};
        bad = (s < -2048) || (s > 2047);
      end
    endcase
`ifdef ENC_RANGE_CHECK_EN
    if (bad) return {2'b10, 32'h0};
`else
    if (bad) w = w;
`endif
    return {2'b00, w};
  endfunction

  // Presents one request, waits for acceptance and checks the N+2 outcome.
  task automatic req(input logic [5:0] o, input logic [4:0] d, input logic [4:0] s1,
                     input logic [4:0] s2, input logic [31:0] im, input logic [1:0] ec,
                     input logic [31:0] w, input string tag);
    int k;
    int n;
    k = sel ? 1 : 0;
    op = o; rd = d; rs1 = s1; rs2 = s2; imm = im; valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!c_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!c_ready) begin
      check({tag, "_ready_timeout"}, 32'd0, 32'd1);
      valid = 1'b0;
      return;
    end
    @(posedge clk); #1 valid = 1'b0;
    @(negedge clk);
    check({tag, "_wr_n1"}, 32'(c_wr), 32'd0);
    @(negedge clk);
    if (ec == 2'b00) begin
      check({tag, "_wr"}, 32'(c_wr), 32'd1);
      check({tag, "_addr"}, c_addr, exp_addr[k]);
      check({tag, "_data"}, c_data, w);
      check({tag, "_noerr"}, 32'(c_err), 32'd0);
      exp_addr[k] = exp_addr[k] + 32'd4;
      exp_cnt[k]++;
    end else begin
      check({tag, "_err"}, 32'(c_err), 32'd1);
      check({tag, "_code"}, 32'(c_code), 32'(ec));
      check({tag, "_nowr"}, 32'(c_wr), 32'd0);
    end
    @(negedge clk);
    check({tag, "_count"}, 32'(c_cnt), exp_cnt[k]);
    check({tag, "_errpulse"}, 32'(c_err), 32'd0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [1:0]  ec;
    logic [31:0] w;
  } vec_t;

  vec_t tab[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [33:0] m;
    logic [31:0] bnd [16];
    logic [31:0] r_imm;
    bnd = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4094, 32'd4096, -32'sd4096,
            -32'sd4098, 32'd1, 32'd31, 32'd32, 32'h000F_FFFF, 32'h0010_0000, 32'd1048574,
            32'd1048576, -32'sd1048576};

    tab.push_back('{6'd18, 5'd1, 5'd0, 5'd0, 32'd5,        2'b00, 32'h0050_0093});
    tab.push_back('{6'd27, 5'd3, 5'd1, 5'd2, 32'd0,        2'b00, 32'h0020_81B3});
    tab.push_back('{6'd28, 5'd3, 5'd1, 5'd2, 32'd0,        2'b00, 32'h4020_81B3});
    tab.push_back('{6'd17, 5'd0, 5'd1, 5'd2, 32'd8,        2'b00, 32'h0020_A423});
    tab.push_back('{6'd4,  5'd0, 5'd1, 5'd2, -32'sd4,      2'b00, 32'hFE20_8EE3});
    tab.push_back('{6'd0,  5'd5, 5'd0, 5'd0, 32'h12345,    2'b00, 32'h1234_52B7});
    tab.push_back('{6'd40, 5'd1, 5'd1, 5'd1, 32'd0,        2'b01, 32'h0});
    tab.push_back('{6'd2,  5'd1, 5'd0, 5'd0, 32'd8,        2'b00, 32'h0080_00EF});
    tab.push_back('{6'd3,  5'd1, 5'd2, 5'd0, 32'd0,        2'b00, 32'h0001_00E7});
    tab.push_back('{6'd26, 5'd1, 5'd1, 5'd0, 32'd3,        2'b00, 32'h4030_D093});
    tab.push_back('{6'd12, 5'd2, 5'd1, 5'd0, 32'd4,        2'b00, 32'h0040_A103});
    tab.push_back('{6'd1,  5'd1, 5'd0, 5'd0, 32'd1,        2'b00, 32'h0000_1097});
    tab.push_back('{6'd63, 5'd0, 5'd0, 5'd0, 32'd0,        2'b01, 32'h0});
`ifdef ENC_RANGE_CHECK_EN
    tab.push_back('{6'd18, 5'd1, 5'd0, 5'd0, 32'd2048,     2'b10, 32'h0});
    tab.push_back('{6'd2,  5'd0, 5'd0, 5'd0, 32'd3,        2'b10, 32'h0});
    tab.push_back('{6'd5,  5'd0, 5'd1, 5'd2, 32'd4096,     2'b10, 32'h0});
    tab.push_back('{6'd24, 5'd1, 5'd1, 5'd0, 32'd32,       2'b10, 32'h0});
    tab.push_back('{6'd0,  5'd0, 5'd0, 5'd0, 32'h0010_0000, 2'b10, 32'h0});
`else
    tab.push_back('{6'd18, 5'd1, 5'd0, 5'd0, 32'd2048,     2'b00, 32'h8000_0093});
    tab.push_back('{6'd2,  5'd0, 5'd0, 5'd0, 32'd3,        2'b00, 32'h0020_006F});
    tab.push_back('{6'd24, 5'd1, 5'd1, 5'd0, 32'd32,       2'b00, 32'h0000_9093});
    tab.push_back('{6'd0,  5'd0, 5'd0, 5'd0, 32'h0010_0000, 2'b00, 32'h0000_0037});
`endif
    tab.push_back('{6'd18, 5'd2, 5'd2, 5'd0, 32'd1,        2'b00, 32'h0011_0113});

    rst_n = 1'b0; valid = 1'b0; clear = 1'b0; sel = 1'b0;
    op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    exp_addr[0] = 32'h0; exp_addr[1] = BASE_B; exp_cnt[0] = 0; exp_cnt[1] = 0;

    #12;
    check("rst_wr", 32'(a_wr), 32'd0);
    check("rst_err", 32'(a_err), 32'd0);
    check("rst_code", 32'(a_code), 32'd0);
    check("rst_full", 32'(a_full), 32'd0);
    check("rst_count", 32'(a_cnt), 32'd0);
    check("rst_addr", a_addr, 32'h0);
    check("rst_data", a_data, 32'h0);
    check("rst_addr_b", b_addr, BASE_B);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(a_ready), 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < tab.size(); i++)
      req(tab[i].op, tab[i].rd, tab[i].rs1, tab[i].rs2, tab[i].imm, tab[i].ec, tab[i].w,
          $sformatf("vec%0d", i));

    for (int i = 0; i < 150; i++) begin
      logic [5:0] r_op;
      logic [4:0] r_rd, r_s1, r_s2;
      r_op = 6'($urandom_range(0, 40));
      r_rd = 5'($urandom); r_s1 = 5'($urandom); r_s2 = 5'($urandom);
      case ($urandom_range(0, 3))
        0: r_imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        1: r_imm = $urandom;
        2: r_imm = bnd[$urandom_range(0, 15)];
        default: r_imm = 32'($urandom_range(0, 31));
      endcase
      m = model_enc(r_op, r_rd, r_s1, r_s2, r_imm);
      req(r_op, r_rd, r_s1, r_s2, r_imm, m[33:32], m[31:0], $sformatf("rnd%0d", i));
    end

    // Reset asserted while a write strobe is active
    sel = 1'b0;
    op = 6'd27; rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2; imm = '0; valid = 1'b1;
    @(negedge clk);
    check("mid_ready", 32'(a_ready), 32'd1);
    @(posedge clk); #1 valid = 1'b0;
    @(posedge clk); #2;
    check("mid_pre_wr", 32'(a_wr), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_wr", 32'(a_wr), 32'd0);
    check("mid_addr", a_addr, 32'h0);
    check("mid_data", a_data, 32'h0);
    check("mid_count", 32'(a_cnt), 32'd0);
    check("mid_code", 32'(a_code), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_wr%0d", i), 32'(a_wr), 32'd0);
    end
    check("post_rst_ready", 32'(a_ready), 32'd1);
    exp_addr[0] = 32'h0; exp_addr[1] = BASE_B; exp_cnt[0] = 0; exp_cnt[1] = 0;
    @(posedge clk); #1;

    // DEPTH=2 instance: fill, hold a third request, clear, then accept it
    sel = 1'b1;
    req(6'd18, 5'd1, 5'd0, 5'd0, 32'd5, 2'b00, 32'h0050_0093, "d2_w0");
    req(6'd27, 5'd3, 5'd1, 5'd2, 32'd0, 2'b00, 32'h0020_81B3, "d2_w1");
    check("d2_full", 32'(b_full), 32'd1);
    check("d2_ready", 32'(b_ready), 32'd0);
    op = 6'd28; rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2; imm = '0; valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("d2_hold_wr%0d", i), 32'(b_wr), 32'd0);
      check($sformatf("d2_hold_rdy%0d", i), 32'(b_ready), 32'd0);
    end
    check("d2_hold_count", 32'(b_cnt), 32'd2);
    @(posedge clk); #1 valid = 1'b0; clear = 1'b1;
    @(negedge clk);
    check("d2_clr_ready", 32'(b_ready), 32'd0);
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk);
    check("d2_clr_full", 32'(b_full), 32'd0);
    check("d2_clr_count", 32'(b_cnt), 32'd0);
    check("d2_clr_addr", b_addr, BASE_B);
    exp_addr[1] = BASE_B; exp_cnt[1] = 0;
    @(posedge clk); #1;
    req(6'd28, 5'd3, 5'd1, 5'd2, 32'd0, 2'b00, 32'h4020_81B3, "d2_w2");
    check("d2_final_full", 32'(b_full), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
